// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: turns one register-access request (7-bit slave address,
// 8-bit register index, single data byte read or write) into the
// cmd/dat/ws command sequence executed by i2c_master. It then reports
// completion, status and read data back to the requester.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_vld/req_rdy          request handshake (ready only when idle)
//   req_rnw/addr/reg/wdat    request fields, latched on accept
//   rsp_done                 one-cycle completion pulse
//   rsp_err                  0 ok, 1 master bus error, 2 watchdog timeout
//   rsp_rdat                 last successfully read byte
//   cmd/dat/ws               command port towards the master
//   stat/mdat                master status and read data
//
// Command bits: STRT=0 STOP=1 WRTE=2 READ=3 NACK=4 CLRS=5.
// Status bits:  SB_BSY=0 SB_ERR=1.
module i2c_reg_seq #(
    parameter int TMO  = 1000000,
    parameter int C_SZ = 6,
    parameter int S_SZ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic            req_rnw,
    input  logic [6:0]      req_addr,
    input  logic [7:0]      req_reg,
    input  logic [7:0]      req_wdat,
    output logic            rsp_done,
    output logic [1:0]      rsp_err,
    output logic [7:0]      rsp_rdat,
    output logic [C_SZ-1:0] cmd,
    output logic [7:0]      dat,
    output logic            ws,
    input  logic [S_SZ-1:0] stat,
    input  logic [7:0]      mdat
);

    localparam logic [C_SZ-1:0] C_STRT = C_SZ'(1);
    localparam logic [C_SZ-1:0] C_STOP = C_SZ'(2);
    localparam logic [C_SZ-1:0] C_WRTE = C_SZ'(4);
    localparam logic [C_SZ-1:0] C_READ = C_SZ'(8);
    localparam logic [C_SZ-1:0] C_NACK = C_SZ'(16);
    localparam logic [C_SZ-1:0] C_CLRS = C_SZ'(32);
    localparam int SB_BSY = 0;
    localparam int SB_ERR = 1;

    localparam logic [1:0] ERR_BUS = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam int WD_W = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE, S_WBSY, S_WDONE,
        S_ERR_CLR, S_ERR_WAIT, S_ERR_STP, S_STP_BSY, S_STP_DONE, S_STP_CLR,
        S_FIN
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      step_reg, step_next;
    logic            rnw_reg;
    logic [6:0]      addr_reg;
    logic [7:0]      idx_reg, wdat_reg;
    logic [1:0]      err_reg, err_next;
    logic [7:0]      rdat_reg, rdat_next;
    logic [C_SZ-1:0] cmd_reg, cmd_next;
    logic [7:0]      dat_reg, dat_next;
    logic            ws_reg, ws_next;
    logic            hold_reg, hold_next;
    logic [WD_W-1:0] wd_reg;

    logic bsy, serr, wd_count, wd_expired, accept;
    logic [1:0] last_step;

    assign bsy        = stat[SB_BSY];
    assign serr       = stat[SB_ERR];
    assign accept     = (state_reg == S_IDLE) && req_vld;
    assign last_step  = rnw_reg ? 2'd3 : 2'd2;
    assign wd_count   = (state_reg == S_WBSY) || (state_reg == S_WDONE) ||
                        (state_reg == S_STP_BSY) || (state_reg == S_STP_DONE);
    assign wd_expired = wd_count && (wd_reg == WD_W'(TMO - 1));

    assign req_rdy  = (state_reg == S_IDLE) && !rst;
    assign rsp_done = (state_reg == S_FIN);
    assign rsp_err  = err_reg;
    assign rsp_rdat = rdat_reg;
    assign cmd      = cmd_reg;
    assign dat      = dat_reg;
    assign ws       = ws_reg;

    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        err_next   = err_reg;
        rdat_next  = rdat_reg;
        cmd_next   = cmd_reg;
        dat_next   = dat_reg;
        hold_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req_vld) begin
                    step_next  = 2'd0;
                    err_next   = 2'd0;
                    cmd_next   = C_STRT | C_WRTE;
                    dat_next   = {req_addr, 1'b0};
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WBSY;
            S_WBSY: begin
                if (wd_expired) begin
                    err_next   = ERR_TMO;
                    state_next = S_ERR_CLR;
                end else if (serr) begin
                    err_next   = ERR_BUS;
                    state_next = S_ERR_CLR;
                end else if (bsy) begin
                    state_next = S_WDONE;
                end
            end
            S_WDONE: begin
                if (wd_expired) begin
                    err_next   = ERR_TMO;
                    state_next = S_ERR_CLR;
                end else if (!bsy) begin
                    if (serr) begin
                        err_next   = ERR_BUS;
                        state_next = S_ERR_CLR;
                    end else if (step_reg == last_step) begin
                        if (rnw_reg) rdat_next = mdat;
                        state_next = S_FIN;
                    end else begin
                        step_next  = step_reg + 2'd1;
                        state_next = S_ISSUE;
                        case (step_reg)
                            2'd0: begin
                                cmd_next = C_WRTE;
                                dat_next = idx_reg;
                            end
                            2'd1: begin
                                cmd_next = rnw_reg ? (C_STRT | C_WRTE) : (C_WRTE | C_STOP);
                                dat_next = rnw_reg ? {addr_reg, 1'b1} : wdat_reg;
                            end
                            default: begin
                                cmd_next = C_READ | C_NACK | C_STOP;
                                dat_next = 8'h00;
                            end
                        endcase
                    end
                end
            end
            S_ERR_CLR: state_next = S_ERR_WAIT;
            S_ERR_WAIT: begin
                // two idle cycles between the clear and the recovery STOP
                hold_next = !hold_reg;
                if (hold_reg) state_next = S_ERR_STP;
            end
            S_ERR_STP: state_next = S_STP_BSY;
            S_STP_BSY: begin
                if (wd_expired) begin
                    // the first recorded fault keeps its code
                    if (err_reg == 2'd0) err_next = ERR_TMO;
                    state_next = S_FIN;
                end else if (serr) begin
                    state_next = S_STP_CLR;
                end else if (bsy) begin
                    state_next = S_STP_DONE;
                end
            end
            S_STP_DONE: begin
                if (wd_expired) begin
                    if (err_reg == 2'd0) err_next = ERR_TMO;
                    state_next = S_FIN;
                end else if (!bsy) begin
                    state_next = serr ? S_STP_CLR : S_FIN;
                end
            end
            S_STP_CLR: state_next = S_FIN;
            S_FIN:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // Recovery commands; these states always last a single cycle, so
        // cmd/dat only change on entry and never while ws is high.
        case (state_next)
            S_ERR_CLR, S_STP_CLR: begin
                cmd_next = C_CLRS;
                dat_next = 8'h00;
            end
            S_ERR_STP: begin
                cmd_next = C_STOP;
                dat_next = 8'h00;
            end
            default: ;
        endcase
        ws_next = (state_next == S_ISSUE) || (state_next == S_ERR_CLR) ||
                  (state_next == S_ERR_STP) || (state_next == S_STP_CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            step_reg  <= 2'd0;
            rnw_reg   <= 1'b0;
            addr_reg  <= 7'd0;
            idx_reg   <= 8'd0;
            wdat_reg  <= 8'd0;
            err_reg   <= 2'd0;
            rdat_reg  <= 8'd0;
            cmd_reg   <= '0;
            dat_reg   <= 8'd0;
            ws_reg    <= 1'b0;
            hold_reg  <= 1'b0;
            wd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            err_reg   <= err_next;
            rdat_reg  <= rdat_next;
            cmd_reg   <= cmd_next;
            dat_reg   <= dat_next;
            ws_reg    <= ws_next;
            hold_reg  <= hold_next;
            if (accept) begin
                rnw_reg  <= req_rnw;
                addr_reg <= req_addr;
                idx_reg  <= req_reg;
                wdat_reg <= req_wdat;
            end
            // watchdog reloads on every command strobe
            if (ws_reg)        wd_reg <= '0;
            else if (wd_count) wd_reg <= wd_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: a behavioural master/slave model answers the
// command port; a transaction-level reference predicts each request's
// command list and response, and a monitor checks them as they appear.
module tb_i2c_reg_seq;

    localparam int TMO = 50;
    localparam logic [5:0] C_STRT = 6'd1;
    localparam logic [5:0] C_STOP = 6'd2;
    localparam logic [5:0] C_WRTE = 6'd4;
    localparam logic [5:0] C_READ = 6'd8;
    localparam logic [5:0] C_NACK = 6'd16;
    localparam logic [5:0] C_CLRS = 6'd32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_vld = 1'b0, req_rdy, req_rnw = 1'b0;
    logic [6:0] req_addr = 7'd0;
    logic [7:0] req_reg = 8'd0, req_wdat = 8'd0;
    logic       rsp_done;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdat;
    logic [5:0] cmd;
    logic [7:0] dat;
    logic       ws;
    logic [1:0] stat;
    logic [7:0] mdat;

    always #5 clk = ~clk;

    i2c_reg_seq #(.TMO(TMO), .C_SZ(6), .S_SZ(2)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_reg(req_reg), .req_wdat(req_wdat),
        .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdat(rsp_rdat),
        .cmd(cmd), .dat(dat), .ws(ws), .stat(stat), .mdat(mdat)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit present(input logic [6:0] a);
        return (a == 7'h3b) || (a == 7'h50);
    endfunction

    // ---------------- master + slave model ----------------
    logic       stuck = 1'b0;   // forces stat to "busy forever"
    logic       m_busy, m_err, m_pend, mem_init = 1'b0;
    int         m_cnt;
    logic [1:0] ph;
    logic [7:0] ptr, mdat_q;
    logic [7:0] mem [256];

    assign stat = stuck ? 2'b01 : {m_err, m_busy};
    assign mdat = mdat_q;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_err <= 1'b0; m_pend <= 1'b0; m_cnt <= 0;
            ph <= 2'd0; ptr <= 8'd0; mdat_q <= 8'd0;
            if (!mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5a;
                mem_init <= 1'b1;
            end
        end else begin
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_err  <= m_pend;
                end else m_cnt <= m_cnt - 1;
            end
            if (ws) begin
                if ((cmd & C_CLRS) != 0) begin
                    m_err <= 1'b0; m_pend <= 1'b0;
                end else begin
                    m_busy <= 1'b1;
                    m_cnt  <= int'($urandom_range(1, 5));
                    m_pend <= 1'b0;
                    if ((cmd & C_STRT) != 0 && (cmd & C_WRTE) != 0) begin
                        if (present(dat[7:1])) ph <= dat[0] ? 2'd3 : 2'd1;
                        else begin m_pend <= 1'b1; ph <= 2'd0; end
                    end else if ((cmd & C_WRTE) != 0) begin
                        if (ph == 2'd1) begin ptr <= dat; ph <= 2'd2; end
                        else if (ph == 2'd2) mem[ptr] <= dat;
                    end else if ((cmd & C_READ) != 0) begin
                        mdat_q <= mem[ptr];
                    end
                    if ((cmd & C_STOP) != 0) ph <= 2'd0;
                end
            end
        end
    end

    // ---------------- reference + scoreboard ----------------
    typedef struct packed { logic [5:0] c; logic [7:0] d; logic chk_d; } cmd_t;
    typedef struct packed { logic [1:0] err; logic rnw; logic [7:0] rdat; } rsp_t;
    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    logic [7:0] ref_mem [256];

    task automatic push_expect(input bit rnw, input logic [6:0] a, input logic [7:0] r,
                               input logic [7:0] w);
        rsp_t e;
        e.rnw = rnw; e.rdat = 8'h00;
        exp_cmd.push_back('{C_STRT | C_WRTE, {a, 1'b0}, 1'b1});
        if (stuck || !present(a)) begin
            exp_cmd.push_back('{C_CLRS, 8'h00, 1'b0});
            exp_cmd.push_back('{C_STOP, 8'h00, 1'b0});
            e.err = stuck ? 2'd2 : 2'd1;
        end else begin
            e.err = 2'd0;
            exp_cmd.push_back('{C_WRTE, r, 1'b1});
            if (!rnw) begin
                exp_cmd.push_back('{C_WRTE | C_STOP, w, 1'b1});
                ref_mem[r] = w;
            end else begin
                exp_cmd.push_back('{C_STRT | C_WRTE, {a, 1'b1}, 1'b1});
                exp_cmd.push_back('{C_READ | C_NACK | C_STOP, 8'h00, 1'b0});
                e.rdat = ref_mem[r];
            end
        end
        exp_rsp.push_back(e);
    endtask

    int n_ws = 0, n_done = 0, cyc = 0, last_ws_cyc = 0, clrs_delta = 0;

    always @(negedge clk) begin
        cmd_t ec;
        rsp_t er;
        cyc++;
        if (!rst) begin
            if (ws) begin
                n_ws++;
                if (!stuck && m_busy) chk("ws_while_busy", 32'(m_busy), 32'd0);
                if (cmd == C_CLRS) clrs_delta = cyc - last_ws_cyc;
                last_ws_cyc = cyc;
                if (exp_cmd.size() == 0) chk("unexpected_ws", 32'(cmd), 32'hffff);
                else begin
                    ec = exp_cmd.pop_front();
                    chk("cmd", 32'(cmd), 32'(ec.c));
                    if (ec.chk_d) chk("dat", 32'(dat), 32'(ec.d));
                end
            end
            if (rsp_done) begin
                n_done++;
                $display("rsp %0d: err=%0d rdat=0x%02h", n_done, rsp_err, rsp_rdat);
                if (exp_rsp.size() == 0) chk("unexpected_done", 32'(rsp_done), 32'd0);
                else begin
                    er = exp_rsp.pop_front();
                    chk("rsp_err", 32'(rsp_err), 32'(er.err));
                    if (er.rnw && er.err == 2'd0) chk("rsp_rdat", 32'(rsp_rdat), 32'(er.rdat));
                    chk("cmds_left", 32'(exp_cmd.size()), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send(input bit rnw, input logic [6:0] a, input logic [7:0] r,
                        input logic [7:0] w, input bit keep);
        int n = 0;
        @(negedge clk);
        req_rnw = rnw; req_addr = a; req_reg = r; req_wdat = w; req_vld = 1'b1;
        while (!req_rdy && n < 2000) begin @(negedge clk); n++; end
        if (!req_rdy) begin
            bound_fail("accept");
            req_vld = 1'b0;
            return;
        end
        push_expect(rnw, a, r, w);
        @(posedge clk); #1;
        if (!keep) req_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_rsp.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        if (exp_rsp.size() != 0) begin
            bound_fail("done");
            exp_rsp.delete();
            exp_cmd.delete();
        end
        @(negedge clk);
        chk("idle_rdy", 32'(req_rdy), 32'd1);
    endtask

    logic [6:0] addrs [4];
    int base;

    initial begin
        addrs[0] = 7'h3b; addrs[1] = 7'h50; addrs[2] = 7'h12; addrs[3] = 7'h2a;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5a;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 32'(req_rdy), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", 32'(req_rdy), 32'd1);
        chk("rst_done", 32'(rsp_done), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdat", 32'(rsp_rdat), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_ws", 32'(ws), 32'd0);

        // directed write, then a read returning a known value
        base = n_ws;
        send(1'b0, 7'h3b, 8'h10, 8'ha5, 1'b0);
        wait_idle();
        chk("write_ws_count", 32'(n_ws - base), 32'd3);
        send(1'b0, 7'h3b, 8'h10, 8'h55, 1'b0);
        wait_idle();
        base = n_ws;
        send(1'b1, 7'h3b, 8'h10, 8'h00, 1'b0);
        wait_idle();
        chk("read_ws_count", 32'(n_ws - base), 32'd4);
        chk("read_rdat_hold", 32'(rsp_rdat), 32'h55);

        // absent slave, then recovery
        send(1'b0, 7'h12, 8'h01, 8'h99, 1'b0);
        wait_idle();
        send(1'b0, 7'h50, 8'h02, 8'h3c, 1'b0);
        wait_idle();

        // watchdog with master stuck busy
        stuck = 1'b1;
        send(1'b0, 7'h3b, 8'h20, 8'h11, 1'b0);
        wait_idle();
        stuck = 1'b0;
        chk("tmo_clrs_delay", 32'(clrs_delta), 32'(TMO + 1));

        // reset during step 2 of a read
        base = n_ws;
        send(1'b1, 7'h3b, 8'h10, 8'h00, 1'b0);
        for (int n = 0; n < 200 && n_ws < base + 2; n++) @(negedge clk);
        if (n_ws < base + 2) bound_fail("step2");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cmd.delete();
        exp_rsp.delete();
        #1;
        chk("mid_rst_ws", 32'(ws), 32'd0);
        chk("mid_rst_rdy", 32'(req_rdy), 32'd1);
        send(1'b0, 7'h50, 8'h33, 8'h7e, 1'b0);
        wait_idle();

        // req_vld held high across back-to-back requests
        for (int i = 0; i < 8; i++)
            send(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)],
                 8'($urandom), 8'($urandom), 1'b1);
        req_vld = 1'b0;
        wait_idle();

        // randomized mix
        for (int i = 0; i < 20; i++) begin
            send(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)],
                 8'($urandom_range(0, 7)), 8'($urandom), 1'b0);
            wait_idle();
        end

        chk("final_cmd_queue", 32'(exp_cmd.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-access sequencer sitting directly upstream of `i2c_master`. It accepts one high-level request (7-bit slave address, 8-bit register index, read or write of one data byte) and converts it into the `cmd`/`dat`/`ws` command sequence the master executes. Completion, status and read data go back to the requester. Master errors are recovered with `C_CLRS` plus a STOP, and a watchdog prevents hangs.

## Interface

Parameters:
- `TMO`, 1000000: per-command watchdog in `clk` cycles (counter width derived with `$clog2`).

Ports:
- `clk` input 1: system clock, the same clock as `i2c_master`.
- `rst` input 1: reset, synchronous and active-high.
- `req_vld` input 1: request valid.
- `req_rdy` output 1: sequencer can accept a request (high only in IDLE).
- `req_rnw` input 1: 1 = read, 0 = write.
- `req_addr` input 7: slave address.
- `req_reg` input 8: register index.
- `req_wdat` input 8: write data.
- `rsp_done` output 1: one-cycle pulse when a request finishes.
- `rsp_err` output 2: status qualified by `rsp_done`. 0 = ok, 1 = master `SB_ERR`, 2 = watchdog timeout.
- `rsp_rdat` output 8: read data, valid with `rsp_done` when the request was a read and `rsp_err`=0.
- `cmd` output `C_SZ`: to the master's `cmd`.
- `dat` output 8: to the master's `dat`.
- `ws` output 1: to the master's `ws`.
- `stat` input `S_SZ`: from the master's `stat_out`.
- `mdat` input 8: from the master's `dat_out`.

## Operation

- Reset values: `req_rdy`=0 during reset and 1 in the first cycle after it; `rsp_done`=0, `rsp_err`=0, `rsp_rdat`=0, `cmd`=0, `dat`=0, `ws`=0. FSM enters IDLE and the watchdog is cleared.
- A request is accepted on the `clk` edge where `req_vld & req_rdy`. All request fields are latched on that edge.
- The command list depends on `req_rnw`.
  - Write: (1) `C_STRT|C_WRTE` with `dat={addr,0}`; (2) `C_WRTE` with `dat=reg`; (3) `C_WRTE|C_STOP` with `dat=wdat`.
  - Read: (1) `C_STRT|C_WRTE` with `{addr,0}`; (2) `C_WRTE` with `reg`; (3) `C_STRT|C_WRTE` with `{addr,1}` (repeated start); (4) `C_READ|C_NACK|C_STOP`. After step 4 completes, `mdat` is captured into `rsp_rdat`.
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE: drive `cmd`/`dat`, assert `ws` for exactly one cycle → WBSY.
  - WBSY: wait for `SB_BSY`=1 → WDONE. If `SB_ERR`=1 while waiting → ERR_CLR.
  - WDONE: wait for `SB_BSY`=0. If `SB_ERR`=0, advance to the next step (ISSUE), or to FIN after the last step. If `SB_ERR`=1 → ERR_CLR.
  - ERR_CLR: issue `C_CLRS` (one `ws` pulse), then wait 2 cycles → ERR_STP.
  - ERR_STP: issue `C_STOP`, then wait for not-busy as above. If `SB_ERR` is set again, issue `C_CLRS` once more. Then → FIN.
  - FIN: one-cycle `rsp_done`, `rsp_err` valid → IDLE.
- Error code priority: the first fault recorded wins. A later `SB_ERR` during the recovery STOP does not overwrite a timeout code.
- `cmd` and `dat` hold their values from the `ws` cycle until the next ISSUE; they are never changed while `ws`=1.

## Timing

- Accept → first `ws`: 1 cycle (ws is high in the cycle after accept).
- Step boundary: the next `ws` comes 1 cycle after the cycle in which WDONE sees `SB_BSY`=0.
- Last step done → `rsp_done`: 1 cycle. `rsp_rdat` is updated in the same cycle as `rsp_done` and holds until the next read completes.
- Watchdog: reloads on every `ws` and counts in WBSY, WDONE and ERR_STP.
  - Reaching `TMO` sets the error code to 2 and jumps to ERR_CLR.
  - A timeout inside ERR_STP goes straight to FIN.
- A `req_vld` held while the sequencer is busy is ignored (`req_rdy`=0) and is not queued.
- `rst` mid-transaction: all outputs take their reset values on the next edge, no `rsp_done` is produced, and the master is not sent a STOP. The master shares `rst` and resets with the sequencer.
- `SB_BSY` may rise in the same cycle `ws` falls. WBSY must sample it from the cycle after the `ws` pulse onward.

## Test plan

- Write 0x3b/reg 0x10/data 0xa5 with the bench slave model → bus shows 0x76, 0x10, 0xa5, each ACKed, then STOP. Response: `rsp_done` with `rsp_err`=0. Exactly 3 `ws` pulses.
- Read 0x3b/reg 0x10, slave returns 0x55 → bus shows 0x76, 0x10, repeated start, 0x77, then the read with NACK and STOP. Response: `rsp_rdat`=0x55, `rsp_err`=0. Exactly 4 `ws` pulses.
- Write to absent address 0x12, so the master raises `SB_ERR` after step 1 → `C_CLRS` then `C_STOP` are issued. Response: `rsp_err`=1, bus released (SDA and SCL high), next request succeeds.
- `TMO`=50 with `stat` tied to `SB_BSY`=1 → after 50 cycles `C_CLRS` is issued. Response: `rsp_err`=2, FSM back in IDLE with `req_rdy`=1.
- Pulse `rst` during step 2 of a read → `ws`=0 and `req_rdy`=1 immediately after reset, no `rsp_done`. A fresh write then completes with `rsp_err`=0.
- Hold `req_vld` asserted continuously → requests are accepted back-to-back, only in IDLE. Each accept produces exactly one `rsp_done`, and no `ws` pulse is issued while `SB_BSY`=1.
